adder_6_bit: RTL and testbench
==============================

// Module: adder_6_bit
//
// PURPOSE
//   6-bit binary adder with carry-in and carry-out, built as a ripple chain of six 1-bit full adders.
//   Combinational result ports must settle within 5 ns of any input change.
//   A registered copy of the result, plus a signed-overflow flag, feeds downstream clocked logic.
//   Leaf arithmetic block; instantiated wherever a narrow add is needed.
//
// PARAMETERS
//   none -- width fixed at 6 bits.
//
// PORTS
//   clk          in   1  system clock, rising-edge active
//   rst          in   1  reset, asynchronous, active-high
//   a            in   6  addend A, unsigned (also read as 2's complement for overflow)
//   b            in   6  addend B
//   carry_in     in   1  carry into bit 0
//   sum          out  6  combinational sum bits
//   carry_out    out  1  combinational carry out of bit 5
//   overflow     out  1  combinational signed overflow
//   sum_r        out  6  registered sum
//   carry_out_r  out  1  registered carry_out
//   overflow_r   out  1  registered overflow
//
// BEHAVIOUR
//   - One clock (clk); reset rst is asynchronous and active-high.
//   - Combinational path, independent of clk and rst:
//       {carry_out, sum} = a + b + carry_in, computed at 7 bits.
//     No truncation; max 63+63+1 = 127 -> carry_out=1, sum=6'h3F.
//   - Ripple structure: c[0]=carry_in.
//     For bit i: s[i]=a[i]^b[i]^c[i], c[i+1]=(a[i]&b[i])|(c[i]&(a[i]^b[i])).
//     carry_out=c[6].
//   - overflow = c[5] ^ c[6]: the sum of two same-sign 2's-complement operands changed sign.
//   - Outputs must never be X or Z for any known input; all 8192 input combinations are legal.
//   - Registered path: on posedge clk, sum_r<=sum, carry_out_r<=carry_out, overflow_r<=overflow.
//     Latency is 1 cycle, with no enable and no handshake.
//   - Reset: while rst=1, sum_r=0, carry_out_r=0, overflow_r=0 immediately, no clock needed.
//     The combinational outputs keep tracking the inputs during reset.
//   - Reset deasserted: the first rising edge after deassertion captures the current combinational result.
//   - Reset asserted mid-stream: registered outputs clear at once; the in-flight value is lost.
//
// TESTING
//   1. Exhaustive: drive the 13-bit vector {carry_in,b,a} = 0..8191, wait 5 ns each.
//      -> {carry_out,sum} == a+b+carry_in for every vector.
//   2. a=6'h00, b=6'h00, ci=0 -> sum=0, carry_out=0, overflow=0.
//      a=6'h3F, b=6'h3F, ci=1 -> sum=6'h3F, carry_out=1, overflow=0.
//   3. a=6'h20, b=6'h20, ci=0 -> sum=0, carry_out=1, overflow=1.
//      a=6'h1F, b=6'h00, ci=1 -> sum=6'h20, carry_out=0, overflow=1.
//   4. Full ripple: a=6'h3F, b=6'h00, ci=1 -> sum=0, carry_out=1, settled within 5 ns.
//   5. Registered path: apply a=5, b=9, ci=1 before edge N.
//      -> sum_r=6'h0F, carry_out_r=0 after edge N, not before.
//   6. Assert rst between edges while sum_r=6'h0F.
//      -> sum_r/carry_out_r/overflow_r=0 without a clock edge; sum still 6'h0F.

Source files
------------

// File: rtl/adder_6_bit_if.sv
// Operand and result bundle for the 6-bit adder. The master drives the operands.
// The slave drives both the combinational and the registered results.
interface adder_6_bit_if;
  logic [5:0] a;
  logic [5:0] b;
  logic       carry_in;
  logic [5:0] sum;
  logic       carry_out;
  logic       overflow;
  logic [5:0] sum_r;
  logic       carry_out_r;
  logic       overflow_r;

  modport master (
    output a, b, carry_in,
    input  sum, carry_out, overflow, sum_r, carry_out_r, overflow_r
  );

  modport slave (
    input  a, b, carry_in,
    output sum, carry_out, overflow, sum_r, carry_out_r, overflow_r
  );
endinterface

// File: rtl/adder_6_bit.sv
// 6-bit ripple-carry adder with carry in/out and a signed-overflow flag.
// A copy of all three results is registered with one cycle of latency.
module adder_6_bit (
  input  logic          clk,
  input  logic          rst,
  adder_6_bit_if.slave  bus
);

  logic [6:0] w_c;
  logic [5:0] w_sum;
  logic       w_overflow;

  logic [5:0] r_sum;
  logic       r_carry_out;
  logic       r_overflow;

  // The carry chain is held in one block so each stage reads the carry from the stage before it.
  always_comb begin
    w_c    = '0;
    w_sum  = '0;
    w_c[0] = bus.carry_in;
    for (int i = 0; i < 6; i++) begin
      w_sum[i]  = bus.a[i] ^ bus.b[i] ^ w_c[i];
      w_c[i+1]  = (bus.a[i] & bus.b[i]) | (w_c[i] & (bus.a[i] ^ bus.b[i]));
    end
  end

  assign w_overflow = w_c[5] ^ w_c[6];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sum       <= '0;
      r_carry_out <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_sum       <= w_sum;
      r_carry_out <= w_c[6];
      r_overflow  <= w_overflow;
    end
  end

  assign bus.sum         = w_sum;
  assign bus.carry_out   = w_c[6];
  assign bus.overflow    = w_overflow;
  assign bus.sum_r       = r_sum;
  assign bus.carry_out_r = r_carry_out;
  assign bus.overflow_r  = r_overflow;

endmodule

// File: tb/tb_adder_6_bit.sv
// Testbench for adder_6_bit: exhaustive and directed combinational checks, reset behaviour,
// and random traffic with a scoreboard queue feeding a monitor on the registered outputs.
module tb_adder_6_bit;

  typedef struct packed {
    logic       ov;
    logic       co;
    logic [5:0] sum;
  } exp_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  bit   monEnable;
  exp_t regQ[$];

  adder_6_bit_if bus ();

  adder_6_bit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // The expected result comes from whole-number arithmetic, with a signed reading of the operands used for overflow.
  function automatic exp_t model(input int a, input int b, input int ci);
    exp_t e;
    int   u;
    int   sa;
    int   sb;
    int   s;
    u     = a + b + ci;
    sa    = (a >= 32) ? a - 64 : a;
    sb    = (b >= 32) ? b - 64 : b;
    s     = sa + sb + ci;
    e.sum = u[5:0];
    e.co  = (u > 63);
    e.ov  = (s > 31) || (s < -32);
    return e;
  endfunction

  task automatic applyStimulus(input logic [5:0] a, input logic [5:0] b, input logic ci);
    bus.a        = a;
    bus.b        = b;
    bus.carry_in = ci;
  endtask

  task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] required);
    checks++;
    if (actual !== required) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, required);
    end
  endtask

  // Each registered result follows the push made at the preceding falling edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (monEnable && regQ.size() > 0) begin
      e = regQ.pop_front();
      checkOutput("registered", {bus.overflow_r, bus.carry_out_r, bus.sum_r}, e);
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    exp_t e;
    int   waitCount;
    checks    = 0;
    errors    = 0;
    monEnable = 1'b0;

    rst = 1'b1;
    applyStimulus(6'h15, 6'h2A, 1'b1);
    #1;
    checkOutput("reset_regs", {bus.overflow_r, bus.carry_out_r, bus.sum_r}, 8'h00);
    checkOutput("reset_comb_tracks", {bus.overflow, bus.carry_out, bus.sum}, model(21, 42, 1));

    @(negedge clk);
    rst = 1'b0;

    for (int v = 0; v < 8192; v++) begin
      applyStimulus(v[5:0], v[11:6], v[12]);
      #5;
      checkOutput($sformatf("exhaustive_%0d", v), {bus.overflow, bus.carry_out, bus.sum},
                  model(int'(v[5:0]), int'(v[11:6]), int'(v[12])));
    end

    applyStimulus(6'h00, 6'h00, 1'b0); #5;
    checkOutput("zero", {bus.overflow, bus.carry_out, bus.sum}, {1'b0, 1'b0, 6'h00});
    applyStimulus(6'h3F, 6'h3F, 1'b1); #5;
    checkOutput("max", {bus.overflow, bus.carry_out, bus.sum}, {1'b0, 1'b1, 6'h3F});
    applyStimulus(6'h20, 6'h20, 1'b0); #5;
    checkOutput("neg_overflow", {bus.overflow, bus.carry_out, bus.sum}, {1'b1, 1'b1, 6'h00});
    applyStimulus(6'h1F, 6'h00, 1'b1); #5;
    checkOutput("pos_overflow", {bus.overflow, bus.carry_out, bus.sum}, {1'b1, 1'b0, 6'h20});
    applyStimulus(6'h3F, 6'h00, 1'b1); #5;
    checkOutput("full_ripple", {bus.carry_out, bus.sum}, {1'b0, 1'b1, 6'h00});

    @(negedge clk);
    rst = 1'b1;
    applyStimulus(6'd5, 6'd9, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("reg_before_edge", {bus.overflow_r, bus.carry_out_r, bus.sum_r}, 8'h00);
    @(posedge clk);
    #1;
    checkOutput("reg_after_edge", {bus.overflow_r, bus.carry_out_r, bus.sum_r}, {1'b0, 1'b0, 6'h0F});

    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("midstream_reset_regs", {bus.overflow_r, bus.carry_out_r, bus.sum_r}, 8'h00);
    checkOutput("midstream_reset_comb", {2'b00, bus.sum}, {2'b00, 6'h0F});

    @(negedge clk);
    rst = 1'b0;
    monEnable = 1'b1;
    for (int n = 0; n < 300; n++) begin
      logic [5:0] ra;
      logic [5:0] rb;
      logic       rc;
      @(negedge clk);
      ra = 6'($urandom_range(0, 63));
      rb = 6'($urandom_range(0, 63));
      rc = 1'($urandom_range(0, 1));
      applyStimulus(ra, rb, rc);
      e = model(int'(ra), int'(rb), int'(rc));
      regQ.push_back(e);
      #1;
      checkOutput("random_comb", {bus.overflow, bus.carry_out, bus.sum}, e);
    end

    waitCount = 0;
    while (regQ.size() > 0 && waitCount < 10) begin
      @(posedge clk);
      #2;
      waitCount++;
    end
    checkOutput("scoreboard_drained", 8'(regQ.size()), 8'h00);
    monEnable = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
